regfile_wsel_pipe: RTL
======================

# regfile_wsel_pipe

Parametrised, registered write-select decoder for the register file write port. It converts an ADDR_W-bit write address plus enable into a 2^ADDR_W-bit one-hot write-select vector. A valid/ready handshake on both sides and a two-entry elastic buffer let the register file back-pressure the datapath without losing or reordering writes. Optionally, writes to the hardwired zero register are suppressed and counted.

## Interface
- ADDR_W, 5, write-address width; output count NSEL = 2**ADDR_W (derived, not overridable)
- clk  input  1  rising-edge clock
- reset_n  input  1  reset, synchronous, active-low
- in_valid  input  1  upstream write request present
- in_ready  output  1  block can accept a request this cycle
- in_addr  input  ADDR_W  destination register index
- in_en  input  1  write enable; 0 means a null op that still flows through
- out_valid  output  1  out_sel/out_addr hold a decoded request
- out_ready  input  1  register file consumes the output this cycle
- out_sel  output  NSEL  one-hot write select, all-zero for null/masked ops
- out_addr  output  ADDR_W  address of the request at the output
- drop_cnt  output  8  saturating count of masked zero-register writes

## Operation
- Accept on in_valid && in_ready; emit on out_valid && out_ready.
- Decode: out_sel[i] = in_en && (in_addr == i), captured at accept time. At most one bit is set.
- Storage: output register (OR) plus skid register (SR); FIFO order is always preserved.
- States:
  - EMPTY: nothing held; out_valid=0. On accept, load OR and go to ONE.
  - ONE: OR valid. Accept with no emit: load SR, go to TWO. Emit with no accept: go to EMPTY. Accept and emit together: reload OR, stay in ONE.
  - TWO: OR and SR valid; in_ready=0. Emit: SR moves to OR, go to ONE. No emit: hold.
- in_ready = reset_n && (state != TWO). This is combinational from state and reset_n only, never from in_valid.
- Null ops (in_en=0) occupy a slot and emit with out_sel=0; out_addr carries in_addr.
- Reset (reset_n low at a clk edge), including mid-operation: state=EMPTY, out_valid=0, out_sel=0, out_addr=0, drop_cnt=0. Any held requests are discarded. in_ready=0 while reset_n is low.

## Timing
- Latency: a request accepted at edge t is visible on the outputs after edge t, when OR was empty or emptying.
- Throughput: one request per cycle while out_ready=1.
- All outputs are registered except in_ready.
- out_sel, out_addr and out_valid are stable while out_valid=1 and out_ready=0.
- drop_cnt updates at the accepting edge, not the emitting edge.

## Configuration
- Macro: REGFILE_WSEL_ZMASK_EN.
- When defined: a request with in_en=1 and in_addr = NSEL-1 (zero register) is stored with out_sel=0 and still emitted with its address. drop_cnt increments at accept, saturating at 255.
- When undefined: address NSEL-1 decodes normally and drop_cnt is tied to 0.

## Test plan
- Reset then single write: reset_n=0 for 2 cycles, then in_valid=1, in_en=1, in_addr=3, out_ready=1. Required: out_valid=1 the next cycle with out_sel=32'h0000_0008 and out_addr=3; in_ready=0 during reset.
- Null op: in_en=0, in_addr=7. Required: out_valid=1, out_sel=0, out_addr=7, drop_cnt unchanged.
- Back-pressure: out_ready=0 and three consecutive requests with addr 1, 2, 4. Required: in_ready drops after the 2nd accept and the 3rd is held upstream. Then out_ready=1 gives outputs 0x2, 0x4, 0x10 in order, and in_ready reasserts.
- Streaming: out_ready=1, addr 0..31 on consecutive cycles. Required: 32 back-to-back one-hot outputs, state stays ONE, no bubbles.
- Zero mask (macro defined): 300 writes to addr 31 with in_en=1. Required: every out_sel=0, drop_cnt saturates at 255. Without the macro: out_sel=32'h8000_0000 and drop_cnt stays 0.
- Mid-operation reset: fill to TWO, then pulse reset_n=0 for one edge. Required: out_valid=0, out_sel=0, drop_cnt=0, and no stale request emitted afterwards.

Source files
------------

// File: rtl/regfile_wsel_pipe.sv
// Registered one-hot write-select decoder with valid/ready on both sides and a two-entry skid buffer.
// Optional macro REGFILE_WSEL_ZMASK_EN suppresses and counts writes to the zero register (index NSEL-1).
module regfile_wsel_pipe #(
  parameter int ADDR_W = 5,
  localparam int NSEL = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              in_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NSEL-1:0]   out_sel,
  output logic [ADDR_W-1:0] out_addr,
  output logic [7:0]        drop_cnt,
  output logic [1:0]        dbg_state
);

  // Handshake: a transfer happens on a side exactly when valid && ready are both high at a
  // rising edge; once out_valid is high, out_sel/out_addr stay put until out_ready is seen.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t state, state_nx;

  logic              accept;
  logic              emit;
  logic              load_or_in;
  logic              load_or_sr;
  logic              load_sr;
  logic [NSEL-1:0]   dec_sel;
  logic [NSEL-1:0]   sr_sel;
  logic [ADDR_W-1:0] sr_addr;

`ifdef REGFILE_WSEL_ZMASK_EN
  logic zero_hit;
  assign zero_hit = in_en && (in_addr == {ADDR_W{1'b1}});
`endif

  always_comb begin
    dec_sel = '0;
    for (int i = 0; i < NSEL; i++) begin
      dec_sel[i] = in_en && (in_addr == ADDR_W'(i));
    end
`ifdef REGFILE_WSEL_ZMASK_EN
    if (zero_hit) dec_sel = '0;
`endif
  end

  assign out_valid = (state != ST_EMPTY);
  assign accept    = in_valid && in_ready;
  assign emit      = out_valid && out_ready;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_EMPTY;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_EMPTY: if (accept) state_nx = ST_ONE;
      ST_ONE: begin
        if (accept && !emit)      state_nx = ST_TWO;
        else if (!accept && emit) state_nx = ST_EMPTY;
      end
      ST_TWO:   if (emit) state_nx = ST_ONE;
      default:  state_nx = ST_EMPTY;
    endcase
  end

  always_comb begin
    in_ready   = reset_n && (state != ST_TWO);
    load_or_in = 1'b0;
    load_or_sr = 1'b0;
    load_sr    = 1'b0;
    case (state)
      ST_EMPTY: load_or_in = accept;
      ST_ONE: begin
        load_or_in = accept && emit;
        load_sr    = accept && !emit;
      end
      ST_TWO:   load_or_sr = emit;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_sel  <= '0;
      out_addr <= '0;
      sr_sel   <= '0;
      sr_addr  <= '0;
    end else begin
      if (load_or_in) begin
        out_sel  <= dec_sel;
        out_addr <= in_addr;
      end else if (load_or_sr) begin
        out_sel  <= sr_sel;
        out_addr <= sr_addr;
      end
      if (load_sr) begin
        sr_sel  <= dec_sel;
        sr_addr <= in_addr;
      end
    end
  end

  // The drop counter advances when the request is taken in, not when it leaves.
`ifdef REGFILE_WSEL_ZMASK_EN
  always_ff @(posedge clk) begin
    if (!reset_n)                                    drop_cnt <= 8'd0;
    else if (accept && zero_hit && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end
`else
  assign drop_cnt = 8'd0;
`endif

endmodule
